gesture_power_ctrl: RTL and testbench

GESTURE_POWER_CTRL -- requirements
Module: gesture_power_ctrl

---
 rtl/gesture_power_ctrl.sv | 105 ++++++++++
 tb/tb_gesture_power_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gesture_power_ctrl.sv
// Two-hand gesture power controller for the hood.
// Left then right powers on, right then left powers off, the key toggles.
module gesture_power_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] gesture_time,
    input  logic        left_pulse,
    input  logic        right_pulse,
    input  logic        key_pulse,
    output logic        power_status,
    output logic        toggle_pulse,
    output logic        armed,
    output logic [29:0] window_remaining
);

    typedef enum logic [1:0] {
        OFF_IDLE,
        OFF_ARMED,
        ON_IDLE,
        ON_ARMED
    } state_t;

    state_t state;
    logic   ps_q;
    logic   last;

    // A count of 0 or 1 means this is the final cycle of the window.
    assign last = (window_remaining[29:1] == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= OFF_IDLE;
            power_status     <= 1'b0;
            armed            <= 1'b0;
            window_remaining <= '0;
            toggle_pulse     <= 1'b0;
            ps_q             <= 1'b0;
        end else begin
            ps_q         <= power_status;
            toggle_pulse <= power_status ^ ps_q;
            if (key_pulse) begin
                power_status     <= ~power_status;
                armed            <= 1'b0;
                window_remaining <= '0;
                state            <= power_status ? OFF_IDLE : ON_IDLE;
            end else begin
                unique case (state)
                    OFF_IDLE: begin
                        if (left_pulse && !right_pulse) begin
                            state            <= OFF_ARMED;
                            armed            <= 1'b1;
                            window_remaining <= gesture_time;
                        end
                    end
                    OFF_ARMED: begin
                        if (right_pulse) begin
                            state            <= ON_IDLE;
                            power_status     <= 1'b1;
                            armed            <= 1'b0;
                            window_remaining <= '0;
                        end else if (left_pulse) begin
                            window_remaining <= gesture_time;
                        end else if (last) begin
                            state            <= OFF_IDLE;
                            armed            <= 1'b0;
                            window_remaining <= '0;
                        end else begin
                            window_remaining <= window_remaining - 30'd1;
                        end
                    end
                    ON_IDLE: begin
                        if (right_pulse && !left_pulse) begin
                            state            <= ON_ARMED;
                            armed            <= 1'b1;
                            window_remaining <= gesture_time;
                        end
                    end
                    ON_ARMED: begin
                        if (left_pulse) begin
                            state            <= OFF_IDLE;
                            power_status     <= 1'b0;
                            armed            <= 1'b0;
                            window_remaining <= '0;
                        end else if (right_pulse) begin
                            window_remaining <= gesture_time;
                        end else if (last) begin
                            state            <= ON_IDLE;
                            armed            <= 1'b0;
                            window_remaining <= '0;
                        end else begin
                            window_remaining <= window_remaining - 30'd1;
                        end
                    end
                    default: begin
                        state            <= OFF_IDLE;
                        power_status     <= 1'b0;
                        armed            <= 1'b0;
                        window_remaining <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gesture_power_ctrl.sv
// Bench for gesture_power_ctrl: directed scenarios plus random
// pulses against a deadline-based reference model.
module tb_gesture_power_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [29:0] gesture_time = 30'd5;
    logic        left_pulse = 1'b0;
    logic        right_pulse = 1'b0;
    logic        key_pulse = 1'b0;
    logic        power_status;
    logic        toggle_pulse;
    logic        armed;
    logic [29:0] window_remaining;

    gesture_power_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .gesture_time     (gesture_time),
        .left_pulse       (left_pulse),
        .right_pulse      (right_pulse),
        .key_pulse        (key_pulse),
        .power_status     (power_status),
        .toggle_pulse     (toggle_pulse),
        .armed            (armed),
        .window_remaining (window_remaining)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit run   = 1'b0;

    task automatic chk(input string name, input longint got,
                       input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d",
                     name, $time, got, exp);
        end
    endtask

    // Reference model: a window is a deadline measured from the edge
    // that last loaded it, not a down-counter.
    longint t      = 0;
    longint arm_t  = 0;
    longint arm_g  = 0;
    bit     active = 1'b0;
    bit     on     = 1'b0;
    bit     on_d   = 1'b0;
    bit     e_tog  = 1'b0;
    bit     e_arm  = 1'b0;
    longint e_rem  = 0;

    function automatic bit is_open(input longint now);
        longint lim;
        lim = (arm_g < 1) ? 1 : arm_g;
        return active && ((now - arm_t) < lim);
    endfunction

    initial forever begin
        bit op, l, r, k;
        @(posedge clk or negedge rst);
        if (!rst) begin
            active = 1'b0;
            on     = 1'b0;
            on_d   = 1'b0;
            e_tog  = 1'b0;
            e_arm  = 1'b0;
            e_rem  = 0;
        end else begin
            l  = left_pulse;
            r  = right_pulse;
            k  = key_pulse;
            op = is_open(t);
            t  = t + 1;
            e_tog = (on != on_d);
            on_d  = on;
            if (k) begin
                on     = !on;
                active = 1'b0;
            end else if (op) begin
                if (on ? l : r) begin
                    on     = !on;
                    active = 1'b0;
                end else if (on ? r : l) begin
                    arm_t = t;
                    arm_g = gesture_time;
                end
            end else if (on ? (r && !l) : (l && !r)) begin
                active = 1'b1;
                arm_t  = t;
                arm_g  = gesture_time;
            end
            e_arm = is_open(t);
            e_rem = e_arm ? (arm_g - (t - arm_t)) : 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (run) begin
            chk("model power_status", power_status, on);
            chk("model toggle_pulse", toggle_pulse, e_tog);
            chk("model armed", armed, e_arm);
            chk("model window_remaining", window_remaining, e_rem);
        end
    end

    task automatic cyc(input bit l, input bit r, input bit k);
        left_pulse  = l;
        right_pulse = r;
        key_pulse   = k;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        run = 1'b1;
        chk("reset power_status", power_status, 0);
        chk("reset toggle_pulse", toggle_pulse, 0);
        chk("reset armed", armed, 0);
        chk("reset window", window_remaining, 0);
        rst = 1'b1;

        // left, right three cycles later: power on
        cyc(1, 0, 0);
        chk("s29 armed", armed, 1);
        chk("s29 window", window_remaining, 5);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 1, 0);
        chk("s29 power", power_status, 1);
        chk("s29 armed drop", armed, 0);
        chk("s29 tog early", toggle_pulse, 0);
        cyc(0, 0, 0);
        chk("s29 tog", toggle_pulse, 1);
        cyc(0, 0, 0);
        chk("s29 tog end", toggle_pulse, 0);

        // left with no right: window expires
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("s30 window 5", window_remaining, 5);
        for (int i = 4; i >= 1; i--) begin
            cyc(0, 0, 0);
            chk("s30 countdown", window_remaining, i);
        end
        cyc(0, 0, 0);
        chk("s30 armed", armed, 0);
        chk("s30 window 0", window_remaining, 0);
        chk("s30 power", power_status, 0);

        // power off at window cycle 5, not at cycle 6
        cyc(0, 0, 1);
        cyc(0, 1, 0);
        repeat (4) cyc(0, 0, 0);
        chk("s31 window 1", window_remaining, 1);
        cyc(1, 0, 0);
        chk("s31 off", power_status, 0);
        cyc(0, 0, 1);
        cyc(0, 1, 0);
        repeat (5) cyc(0, 0, 0);
        chk("s31 closed", armed, 0);
        cyc(1, 0, 0);
        chk("s31 late left", power_status, 1);

        // repeat left reloads the window
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        repeat (3) cyc(0, 0, 0);
        chk("s32 window 2", window_remaining, 2);
        cyc(1, 0, 0);
        chk("s32 reload", window_remaining, 5);
        repeat (2) cyc(0, 0, 0);
        cyc(0, 1, 0);
        chk("s32 on", power_status, 1);

        // key and left together: one toggle only
        cyc(0, 1, 0);
        chk("s33 armed", armed, 1);
        cyc(1, 0, 1);
        chk("s33 off", power_status, 0);
        chk("s33 idle", armed, 0);
        cyc(0, 0, 0);
        chk("s33 tog", toggle_pulse, 1);
        cyc(0, 0, 0);
        chk("s33 tog end", toggle_pulse, 0);

        // zero-length setting acts as a one-cycle window
        gesture_time = 30'd0;
        cyc(1, 0, 0);
        chk("g0 armed", armed, 1);
        chk("g0 window", window_remaining, 0);
        cyc(0, 1, 0);
        chk("g0 on", power_status, 1);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        chk("g0 expire", armed, 0);

        // window length is sampled only on load
        gesture_time = 30'd5;
        cyc(0, 1, 0);
        gesture_time = 30'd9;
        cyc(0, 0, 0);
        chk("g sample", window_remaining, 4);
        gesture_time = 30'd5;

        // reset mid-window abandons it
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        repeat (2) cyc(0, 0, 0);
        chk("s34 window 3", window_remaining, 3);
        #2 rst = 1'b0;
        #1;
        chk("s34 power", power_status, 0);
        chk("s34 armed", armed, 0);
        chk("s34 window", window_remaining, 0);
        chk("s34 tog", toggle_pulse, 0);
        @(negedge clk);
        rst = 1'b1;
        cyc(0, 1, 0);
        chk("s34 no on", power_status, 0);
        chk("s34 no arm", armed, 0);

        // random pulses, window lengths and resets
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
            if ($urandom_range(0, 31) == 0)
                gesture_time = 30'($urandom_range(0, 7));
            cyc($urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 19) == 0);
        end

        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
